cf_uart_rx_fifo: RTL and testbench
==================================

CF_UART_RX_FIFO -- requirements
Module: cf_uart_rx_fifo

Interface
REQ-001 Parameter DW, default 8, received character data width in bits.
REQ-002 Parameter AW, default 4, FIFO address width; depth = 2**AW entries.
REQ-003 Parameter TW, default 16, timeout counter width.
REQ-004 clk_i  in  1  single block clock; all logic rising-edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 rx_done  in  1  one-cycle strobe from the UART receiver: character valid.
REQ-007 rx_data  in  DW  received character, valid with rx_done.
REQ-008 rx_err  in  1  framing/parity error for the character, valid with rx_done.
REQ-009 rd  in  1  one-cycle pop request from bus side.
REQ-010 rdata  out  DW  head-entry data.
REQ-011 rerr  out  1  head-entry error flag.
REQ-012 empty  out  1  FIFO holds 0 entries.
REQ-013 full  out  1  FIFO holds 2**AW entries.
REQ-014 level  out  AW+1  current entry count.
REQ-015 threshold  in  AW  watermark level.
REQ-016 above_th  out  1  level > threshold.
REQ-017 tick  in  1  timeout time base strobe (one per bit period).
REQ-018 to_load  in  TW  timeout length in ticks; 0 disables timeout.
REQ-019 timeout  out  1  sticky idle-timeout flag.
REQ-020 overrun  out  1  sticky overrun flag.
REQ-021 clr  in  1  one-cycle clear of timeout and overrun flags.
REQ-022 flush  in  1  one-cycle strobe discarding all entries.

Function
REQ-023 Write: rx_done with !full stores {rx_err, rx_data} at write pointer, pointer +1 mod 2**AW, level +1 next cycle.
REQ-024 Write with full: entry dropped, contents unchanged, overrun set next cycle.
REQ-025 Read: rd with !empty advances read pointer mod 2**AW, level -1; rd with empty ignored, no flag.
REQ-026 rdata/rerr: combinational from head entry (show-ahead); undefined content permitted when empty.
REQ-027 Simultaneous rx_done and rd when full: pop and push both occur, level stays 2**AW, no overrun.
REQ-028 Simultaneous rx_done and rd when empty: push only, rd ignored, level 1.
REQ-029 Simultaneous rx_done and rd otherwise: level unchanged, both pointers advance.
REQ-030 Pointers are AW+1 bits; empty = pointers equal; full = MSBs differ, rest equal; level = wptr - rptr.
REQ-031 above_th, empty, full, level derived combinationally from registered pointers.
REQ-032 Timeout counter: reloads to_load on rx_done, rd, flush, or empty; decrements on tick when !empty and nonzero.
REQ-033 Timeout fires (set next cycle) when counter is 1 and tick arrives with !empty and to_load != 0; counter then holds 0 until reload.
REQ-034 flush: both pointers to 0 next cycle; has priority over same-cycle rx_done and rd (incoming character dropped, no overrun).
REQ-035 clr: clears timeout and overrun; a same-cycle set event wins (flag stays 1).

Reset
REQ-036 rst_i sampled high: pointers 0, level 0, empty 1, full 0, above_th 0, timeout 0, overrun 0, counter = 0.
REQ-037 Reset mid-operation discards all entries; storage array not reset; rx_done during reset ignored.

Structure
REQ-038 Shared package cf_uart_pkg holds default widths (DW, AW, TW) and entry typedef {err, data}.
REQ-039 One sub-module cf_uart_rx_timer holds the timeout counter; storage and pointers stay in the top module.

Verification
REQ-040 Write 0x41,0x42,0x43 (rx_err 0,1,0) -> level 3, rdata 0x41/rerr 0; three rd -> 0x42/1, 0x43/0, empty 1.
REQ-041 AW=4: 17 writes no reads -> full 1 after 16th, 17th dropped, overrun 1, 16 reads return writes 1..16 in order.
REQ-042 Full FIFO, rx_done and rd same cycle -> level 16, overrun 0, tail = new byte; wrap verified over 40 entries.
REQ-043 to_load=10, one write then 10 ticks -> timeout 1 after 10th tick; rd at tick 5 restarts count; to_load=0 never fires.
REQ-044 threshold=3: levels 3 -> above_th 0, 4 -> 1; flush with rx_done same cycle -> level 0, overrun 0.
REQ-045 rst_i pulsed with level 5 and overrun 1 -> next cycle empty 1, level 0, all flags 0.

Source files
------------

// File: rtl/cf_uart_pkg.sv
// Shared defaults and entry layout for the UART receive FIFO slice.
package cf_uart_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 4;
  localparam int DEF_TW = 16;

  // Stored entry: error flag above the character bits.
  typedef struct packed {
    logic              err;
    logic [DEF_DW-1:0] data;
  } cf_uart_entry_t;

endpackage

// File: rtl/cf_uart_rx_timer.sv
// Idle timeout counter: reloads on activity, counts ticks down while data waits.
module cf_uart_rx_timer
  import cf_uart_pkg::*;
#(
  parameter int TW = DEF_TW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          reload_i,
  input  logic          tick_i,
  input  logic          active_i,
  input  logic [TW-1:0] load_i,
  output logic          fire_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Activity wins over a same-cycle tick; a zero reload value never fires.
  always_comb begin
    cnt_d  = cnt_q;
    fire_o = 1'b0;
    if (reload_i) begin
      cnt_d = load_i;
    end else if (tick_i && active_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
      if ((cnt_q == TW'(1)) && (load_i != '0)) fire_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cf_uart_rx_fifo.sv
// UART receive FIFO with show-ahead head, watermark, sticky overrun and idle timeout.
module cf_uart_rx_fifo
  import cf_uart_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int TW = DEF_TW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_done,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_err,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          rerr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW-1:0] threshold,
  output logic          above_th,
  input  logic          tick,
  input  logic [TW-1:0] to_load,
  output logic          timeout,
  output logic          overrun,
  input  logic          clr,
  input  logic          flush
);

  localparam int DEPTH = 1 << AW;

  // Entry layout {err, data}, same ordering as cf_uart_entry_t.
  logic [DW:0]  mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         overrun_q, overrun_d;
  logic         timeout_q, timeout_d;
  logic         pop, push, ovr_set, fire;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level    = wptr_q - rptr_q;
  assign above_th = (level > {1'b0, threshold});
  assign rdata    = mem_q[rptr_q[AW-1:0]][DW-1:0];
  assign rerr     = mem_q[rptr_q[AW-1:0]][DW];
  assign timeout  = timeout_q;
  assign overrun  = overrun_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  always_comb begin
    pop     = rd && !empty && !flush;
    push    = rx_done && !flush && (!full || pop);
    ovr_set = rx_done && !flush && full && !pop;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + (AW+1)'(1);
      if (pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
    overrun_d = ovr_set ? 1'b1 : (clr ? 1'b0 : overrun_q);
    timeout_d = fire    ? 1'b1 : (clr ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wptr_q[AW-1:0]] <= {rx_err, rx_data};
  end

  cf_uart_rx_timer #(.TW(TW)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .reload_i (rx_done || rd || flush || empty),
    .tick_i   (tick),
    .active_i (!empty),
    .load_i   (to_load),
    .fire_o   (fire)
  );

endmodule

// File: tb/tb_cf_uart_rx_fifo.sv
// Scoreboard bench for cf_uart_rx_fifo: directed stimulus, pops checked by a monitor.
module tb_cf_uart_rx_fifo;
  import cf_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_err = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  rdata;
  logic        rerr;
  logic        empty;
  logic        full;
  logic [4:0]  level;
  logic [3:0]  threshold = 4'd3;
  logic        above_th;
  logic        tick = 1'b0;
  logic [15:0] to_load = '0;
  logic        timeout;
  logic        overrun;
  logic        clr = 1'b0;
  logic        flush = 1'b0;

  int checks = 0;
  int failures = 0;
  cf_uart_entry_t expq[$];

  always #5 clk = ~clk;

  cf_uart_rx_fifo #(.DW(8), .AW(4), .TW(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_done(rx_done), .rx_data(rx_data), .rx_err(rx_err),
    .rd(rd), .rdata(rdata), .rerr(rerr), .empty(empty), .full(full), .level(level),
    .threshold(threshold), .above_th(above_th), .tick(tick), .to_load(to_load),
    .timeout(timeout), .overrun(overrun), .clr(clr), .flush(flush)
  );

  // Monitor: every accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    cf_uart_entry_t e;
    if (!rst_i && rd && !empty && !flush) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%h required=none", {rerr, rdata});
      end else begin
        e = expq.pop_front();
        if ({rerr, rdata} !== e) begin
          failures++;
          $display("FAIL pop_data got=%h required=%h", {rerr, rdata}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rd      = 1'b0;
    tick    = 1'b0;
    clr     = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic xfer(input bit w, input logic [7:0] d, input bit e, input bit r, input bit acc);
    cf_uart_entry_t ent;
    rx_done = w;
    rx_data = d;
    rx_err  = e;
    rd      = r;
    if (w && acc) begin
      ent.err  = e;
      ent.data = d;
      expq.push_back(ent);
    end
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    rst_i = 1'b0;
    cyc();
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", {29'd0, above_th, timeout, overrun}, 32'd0);

    // Basic order and show-ahead head
    xfer(1, 8'h41, 0, 0, 1);
    xfer(1, 8'h42, 1, 0, 1);
    xfer(1, 8'h43, 0, 0, 1);
    chk("basic_level", 32'(level), 32'd3);
    chk("basic_head", {23'd0, rerr, rdata}, 32'h041);
    reads(1);
    chk("basic_head2", {23'd0, rerr, rdata}, 32'h142);
    reads(2);
    chk("basic_empty", 32'(empty), 32'd1);

    // Fill past full
    for (int i = 1; i <= 17; i++) begin
      xfer(1, 8'(i), (i % 3) == 0, 0, i <= 16);
      if (i == 16) begin
        chk("fill_full16", 32'(full), 32'd1);
        chk("fill_ovr16", 32'(overrun), 32'd0);
      end
    end
    chk("fill_ovr17", 32'(overrun), 32'd1);
    chk("fill_level17", 32'(level), 32'd16);
    clr = 1'b1;
    cyc();
    chk("clr_ovr", 32'(overrun), 32'd0);

    // Push and pop together on a full FIFO
    xfer(1, 8'hA0, 1, 1, 1);
    chk("fullrw_level", 32'(level), 32'd16);
    chk("fullrw_ovr", 32'(overrun), 32'd0);
    reads(15);
    chk("fullrw_tail", {23'd0, rerr, rdata}, 32'h1A0);
    reads(1);
    chk("fullrw_empty", 32'(empty), 32'd1);

    // Streaming wrap over 40 entries
    for (int k = 0; k < 40; k++) xfer(1, 8'(8'h60 + k), k[0], k >= 3, 1);
    chk("wrap_level", 32'(level), 32'd3);
    reads(3);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Watermark and flush
    for (int i = 0; i < 3; i++) xfer(1, 8'(8'h30 + i), 0, 0, 1);
    chk("th_level3", 32'(above_th), 32'd0);
    xfer(1, 8'h33, 0, 0, 1);
    chk("th_level4", 32'(above_th), 32'd1);
    expq.delete();
    flush = 1'b1;
    xfer(1, 8'hFF, 0, 0, 0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovr", 32'(overrun), 32'd0);

    // Idle timeout
    to_load = 16'd10;
    xfer(1, 8'h11, 0, 0, 1);
    ticks(9);
    chk("to_tick9", 32'(timeout), 32'd0);
    ticks(1);
    chk("to_tick10", 32'(timeout), 32'd1);
    clr = 1'b1;
    cyc();
    chk("to_clr", 32'(timeout), 32'd0);
    xfer(1, 8'h22, 1, 0, 1);
    ticks(4);
    reads(1);
    ticks(9);
    chk("to_restart9", 32'(timeout), 32'd0);
    ticks(1);
    chk("to_restart10", 32'(timeout), 32'd1);
    clr = 1'b1;
    cyc();
    to_load = 16'd0;
    xfer(1, 8'h33, 0, 0, 1);
    ticks(20);
    chk("to_disabled", 32'(timeout), 32'd0);
    reads(2);
    chk("to_drain", 32'(empty), 32'd1);

    // Reset in the middle of traffic
    for (int i = 1; i <= 17; i++) xfer(1, 8'(8'hC0 + i), 0, 0, i <= 16);
    reads(11);
    chk("prerst_level", 32'(level), 32'd5);
    chk("prerst_ovr", 32'(overrun), 32'd1);
    rst_i = 1'b1;
    expq.delete();
    xfer(1, 8'hEE, 0, 0, 0);
    rst_i = 1'b0;
    chk("rst2_empty", 32'(empty), 32'd1);
    chk("rst2_level", 32'(level), 32'd0);
    chk("rst2_flags", {28'd0, full, above_th, timeout, overrun}, 32'd0);
    xfer(1, 8'h5A, 0, 0, 1);
    chk("post_rst_head", {23'd0, rerr, rdata}, 32'h05A);
    reads(1);
    chk("post_rst_empty", 32'(empty), 32'd1);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
